// File: rtl/uart_rx_array.sv
// rtl/uart_rx_array.sv - N-channel oversampling UART receiver merged into one tagged byte stream
// Optional parity stage: define UART_RX_PARITY_EN.
module uart_rx_array #(
  parameter int NUM_CHANNELS = 8,
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_WIDTH    = 16,
  parameter int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [DIV_WIDTH-1:0]    baud_div,
  input  logic [NUM_CHANNELS-1:0] rx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_BITS-1:0]    out_data,
  output logic [CHAN_W-1:0]       out_chan,
  output logic                    out_ferr,
  output logic                    out_perr,
  output logic [NUM_CHANNELS-1:0] overrun,
  input  logic [NUM_CHANNELS-1:0] overrun_clr,
  output logic                    irq
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  logic [DIV_WIDTH-1:0]                   r_presc;
  logic                                   w_tick;
  logic [NUM_CHANNELS-1:0]                r_sync1, r_sync2;
  logic [NUM_CHANNELS-1:0]                w_hold_valid, w_take, w_ovr_set;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] w_hold_data;
  logic [NUM_CHANNELS-1:0]                w_hold_ferr, w_hold_perr;
  logic [CHAN_W-1:0]                      r_last_grant, w_hit, w_idx;
  logic                                   w_found, w_free;
  int                                     w_tmp;

  // >= rather than == so a lowered baud_div cannot strand the counter above it
  assign w_tick = (r_presc >= baud_div);

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_presc <= '0;
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + DIV_WIDTH'(1);
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    state_t               r_state, w_state;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic [BIT_W-1:0]     r_bit, w_bit;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic                 w_done, w_ferr, w_perr, w_sample;
    logic                 r_hv, r_hf, r_hp;
    logic [DATA_BITS-1:0] r_hd;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par;
`endif

    assign w_sample = r_sync2[g];

    always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_bit   = r_bit;
      w_shift = r_shift;
      w_done  = 1'b0;
      w_ferr  = 1'b0;
      w_perr  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par   = r_par;
`endif
      if (w_tick) begin
        case (r_state)
          S_IDLE: if (!w_sample) begin
            w_state = S_START;
            w_cnt   = '0;
          end
          S_START: if (r_cnt == CNT_HALF) begin
            w_cnt = '0;
            w_bit = '0;
            w_state = w_sample ? S_IDLE : S_DATA;
          end else w_cnt = r_cnt + CNT_W'(1);
          S_DATA: if (r_cnt == CNT_FULL) begin
            w_cnt = '0;
            w_shift[r_bit] = w_sample;
            if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state = S_PARITY;
`else
              w_state = S_STOP;
`endif
            end else w_bit = r_bit + BIT_W'(1);
          end else w_cnt = r_cnt + CNT_W'(1);
`ifdef UART_RX_PARITY_EN
          S_PARITY: if (r_cnt == CNT_FULL) begin
            w_cnt   = '0;
            w_par   = w_sample;
            w_state = S_STOP;
          end else w_cnt = r_cnt + CNT_W'(1);
`endif
          S_STOP: if (r_cnt == CNT_FULL) begin
            w_cnt   = '0;
            w_done  = 1'b1;
            w_ferr  = !w_sample;
`ifdef UART_RX_PARITY_EN
            w_perr  = ^{r_shift, r_par};
`endif
            w_state = w_sample ? S_IDLE : S_BREAK;
          end else w_cnt = r_cnt + CNT_W'(1);
          S_BREAK: if (w_sample) w_state = S_IDLE;
          default: w_state = S_IDLE;
        endcase
      end
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_shift <= '0;
        r_hv    <= 1'b0;
        r_hd    <= '0;
        r_hf    <= 1'b0;
        r_hp    <= 1'b0;
      end else begin
        r_state <= w_state;
        r_cnt   <= w_cnt;
        r_bit   <= w_bit;
        r_shift <= w_shift;
        if (w_done && (!r_hv || w_take[g])) begin
          r_hv <= 1'b1;
          r_hd <= r_shift;
          r_hf <= w_ferr;
          r_hp <= w_perr;
        end else if (w_take[g]) begin
          r_hv <= 1'b0;
        end
      end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK) begin
      if (reset) r_par <= 1'b0;
      else       r_par <= w_par;
    end
`endif

    assign w_ovr_set[g]    = w_done & r_hv & ~w_take[g];
    assign w_hold_valid[g] = r_hv;
    assign w_hold_data[g]  = r_hd;
    assign w_hold_ferr[g]  = r_hf;
    assign w_hold_perr[g]  = r_hp;
  end

  always_ff @(posedge CLK) begin
    if (reset) overrun <= '0;
    else       overrun <= w_ovr_set | (overrun & ~overrun_clr);
  end

  assign w_free = !out_valid || out_ready;

  // Rotating-priority search starting just after the last granted channel
  always_comb begin
    w_found = 1'b0;
    w_hit   = r_last_grant;
    w_take  = '0;
    w_tmp   = 0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      w_tmp = int'(r_last_grant) + k;
      if (w_tmp >= NUM_CHANNELS) w_tmp = w_tmp - NUM_CHANNELS;
      w_idx = CHAN_W'(w_tmp);
      if (!w_found && w_hold_valid[w_idx]) begin
        w_found = 1'b1;
        w_hit   = w_idx;
      end
    end
    if (w_free && w_found) w_take[w_hit] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_chan     <= '0;
      out_ferr     <= 1'b0;
      out_perr     <= 1'b0;
      r_last_grant <= CHAN_W'(NUM_CHANNELS - 1);
    end else if (w_free) begin
      if (w_found) begin
        out_valid    <= 1'b1;
        out_data     <= w_hold_data[w_hit];
        out_chan     <= w_hit;
        out_ferr     <= w_hold_ferr[w_hit];
        out_perr     <= w_hold_perr[w_hit];
        r_last_grant <= w_hit;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign irq = out_valid | (|overrun);
endmodule
